lbp_code_gen: RTL and testbench

- Consumer-side counterpart of the 8-neighbour interpolation stage.
- Takes the eight 24-bit 8.16 fixed-point neighbour samples S1..S8 plus the aligned centre pixel, and produces the rotation-invariant uniform LBP label (riu2).
- Also produces the raw 8-bit LBP code, with done/progress flags aligned to the data.
- Sits between interpolation and the histogram/feature stage.

---
 rtl/lbp_code_gen_if.sv | 40 ++++
 rtl/lbp_code_gen.sv | 170 +++++++++++++++++
 tb/tb_lbp_code_gen.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_code_gen_if.sv
// Bus bundle for lbp_code_gen: neighbour samples in, LBP code/label out.
// LBP_MAGNITUDE_EN adds the mag_o signal.
interface lbp_code_gen_if #(
  parameter int CNT_W = 20
);
  // Valid-only stream with no ready: a beat is taken on every clk edge with valid_i=1,
  // and each output beat is presented for exactly one cycle with valid_o=1.
  logic             valid_i;
  logic [7:0]       center_i;
  logic [23:0]      S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i;
  logic             done_i;
  logic             progress_done_i;
  logic             valid_o;
  logic [7:0]       code_o;
  logic [3:0]       riu2_o;
  logic [CNT_W-1:0] code_count_o;
  logic             done_o;
  logic             progress_done_o;
`ifdef LBP_MAGNITUDE_EN
  logic             mag_o;
`endif

  modport master (
    output valid_i, center_i, S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i,
    output done_i, progress_done_i,
`ifdef LBP_MAGNITUDE_EN
    input  mag_o,
`endif
    input  valid_o, code_o, riu2_o, code_count_o, done_o, progress_done_o
  );

  modport slave (
    input  valid_i, center_i, S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i,
    input  done_i, progress_done_i,
`ifdef LBP_MAGNITUDE_EN
    output mag_o,
`endif
    output valid_o, code_o, riu2_o, code_count_o, done_o, progress_done_o
  );
endinterface

// File: rtl/lbp_code_gen.sv
// 4-stage LBP code / riu2 label generator with per-frame beat counter.
// Define LBP_MAGNITUDE_EN to add the CLBP magnitude bit (mag_o).
module lbp_code_gen #(
  parameter int         CNT_W    = 20,
  parameter logic [7:0] M_THRESH = 8'd16
) (
  input logic          clk,
  input logic          rst,
  lbp_code_gen_if.slave bus
);
  logic [23:0] s [8];
  logic [23:0] center_fx;

  assign s[0] = bus.S1_i;
  assign s[1] = bus.S2_i;
  assign s[2] = bus.S3_i;
  assign s[3] = bus.S4_i;
  assign s[4] = bus.S5_i;
  assign s[5] = bus.S6_i;
  assign s[6] = bus.S7_i;
  assign s[7] = bus.S8_i;
  assign center_fx = {bus.center_i, 16'h0000};

  // Stage 1: threshold each neighbour, fractional bits included
  logic [7:0] code_c;
  always_comb begin
    code_c = '0;
    for (int k = 0; k < 8; k++) code_c[k] = (s[k] >= center_fx);
  end

  logic       s1_valid, s1_done, s1_prog;
  logic [7:0] s1_code;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_done  <= 1'b0;
      s1_prog  <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= bus.valid_i;
      s1_done  <= bus.done_i;
      s1_prog  <= bus.progress_done_i;
      s1_code  <= code_c;
    end
  end

  // Stage 2: ones count and circular transition count
  logic [7:0] rot_x;
  logic [3:0] ones_c, trans_c;
  always_comb begin
    rot_x   = s1_code ^ {s1_code[0], s1_code[7:1]};
    ones_c  = '0;
    trans_c = '0;
    for (int k = 0; k < 8; k++) begin
      ones_c  = ones_c + {3'b000, s1_code[k]};
      trans_c = trans_c + {3'b000, rot_x[k]};
    end
  end

  logic       s2_valid, s2_done, s2_prog;
  logic [7:0] s2_code;
  logic [3:0] s2_ones, s2_trans;
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_done  <= 1'b0;
      s2_prog  <= 1'b0;
      s2_code  <= '0;
      s2_ones  <= '0;
      s2_trans <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_done  <= s1_done;
      s2_prog  <= s1_prog;
      s2_code  <= s1_code;
      s2_ones  <= ones_c;
      s2_trans <= trans_c;
    end
  end

  // Stage 3: uniform patterns keep their ones count, all others collapse to 9
  logic       s3_valid, s3_done, s3_prog;
  logic [7:0] s3_code;
  logic [3:0] s3_riu2;
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_done  <= 1'b0;
      s3_prog  <= 1'b0;
      s3_code  <= '0;
      s3_riu2  <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_done  <= s2_done;
      s3_prog  <= s2_prog;
      s3_code  <= s2_code;
      s3_riu2  <= (s2_trans <= 4'd2) ? s2_ones : 4'd9;
    end
  end

  // Stage 4: output registers; the counter clears the cycle after done_o
  logic             valid_r, done_r, prog_r;
  logic [7:0]       code_r;
  logic [3:0]       riu2_r;
  logic [CNT_W-1:0] cnt_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      prog_r  <= 1'b0;
      code_r  <= '0;
      riu2_r  <= '0;
      cnt_r   <= '0;
    end else begin
      valid_r <= s3_valid;
      done_r  <= s3_done;
      prog_r  <= s3_prog;
      if (s3_valid) begin
        code_r <= s3_code;
        riu2_r <= s3_riu2;
      end
      if (done_r) cnt_r <= {{(CNT_W-1){1'b0}}, s3_valid};
      else        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, s3_valid};
    end
  end

  assign bus.valid_o         = valid_r;
  assign bus.done_o          = done_r;
  assign bus.progress_done_o = prog_r;
  assign bus.code_o          = code_r;
  assign bus.riu2_o          = riu2_r;
  assign bus.code_count_o    = cnt_r;

`ifdef LBP_MAGNITUDE_EN
  // Mean |diff| >= M_THRESH is tested as sum >= 8*M_THRESH
  localparam logic [10:0] MAG_LIMIT = {M_THRESH, 3'b000};

  logic [7:0]  d_c [8];
  logic [7:0]  s1_d [8];
  logic [10:0] sum_c, s2_sum;
  logic        s3_mag, mag_r;

  always_comb begin
    for (int k = 0; k < 8; k++)
      d_c[k] = (s[k][23:16] >= bus.center_i) ? (s[k][23:16] - bus.center_i)
                                             : (bus.center_i - s[k][23:16]);
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < 8; k++) sum_c = sum_c + {3'b000, s1_d[k]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) s1_d[k] <= '0;
      s2_sum <= '0;
      s3_mag <= 1'b0;
      mag_r  <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) s1_d[k] <= d_c[k];
      s2_sum <= sum_c;
      s3_mag <= (s2_sum >= MAG_LIMIT);
      if (s3_valid) mag_r <= s3_mag;
    end
  end

  assign bus.mag_o = mag_r;
`endif
endmodule

// File: tb/tb_lbp_code_gen.sv
// Bench for lbp_code_gen: directed vector table, frame/reset/wrap sequences, random traffic.
// Checks mag_o as well when LBP_MAGNITUDE_EN is defined.
module tb_lbp_code_gen;
  localparam int         TB_CNT_W = 4;
  localparam logic [7:0] TB_THRESH = 8'd16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lbp_code_gen_if #(.CNT_W(TB_CNT_W)) bus ();
  lbp_code_gen #(.CNT_W(TB_CNT_W), .M_THRESH(TB_THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        done;
    logic        prog;
    logic [7:0]  center;
    logic [23:0] s [8];
  } rec_t;

  typedef struct {
    logic [7:0]  center;
    logic [23:0] s [8];
    logic [7:0]  exp_code;
    logic [3:0]  exp_riu2;
  } vec_t;

  int total = 0;
  int bad   = 0;

  rec_t hist [$];
  logic [TB_CNT_W-1:0] exp_q [$];
  logic [7:0]          m_code = '0;
  logic [3:0]          m_riu2 = '0;
  logic [TB_CNT_W-1:0] m_cnt  = '0;
  logic                m_prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: label derived by counting bits and neighbour changes around the ring
  task automatic ref_out(input rec_t r, output logic [7:0] code, output logic [3:0] riu2,
                         output logic mag);
    int ones, trans, sum, d;
    ones = 0; trans = 0; sum = 0;
    for (int k = 0; k < 8; k++) begin
      code[k] = (int'(r.s[k]) >= int'(r.center) * 65536);
      d = int'(r.s[k] >> 16) - int'(r.center);
      sum += (d < 0) ? -d : d;
    end
    for (int k = 0; k < 8; k++) begin
      ones  += int'(code[k]);
      trans += (code[k] != code[(k + 1) % 8]) ? 1 : 0;
    end
    riu2 = (trans <= 2) ? 4'(ones) : 4'd9;
    mag  = (sum >= int'(TB_THRESH) * 8);
  endtask

  task automatic drive(input rec_t r);
    rst                 = r.rst;
    bus.valid_i         = r.valid;
    bus.done_i          = r.done;
    bus.progress_done_i = r.prog;
    bus.center_i        = r.center;
    bus.S1_i = r.s[0]; bus.S2_i = r.s[1]; bus.S3_i = r.s[2]; bus.S4_i = r.s[3];
    bus.S5_i = r.s[4]; bus.S6_i = r.s[5]; bus.S7_i = r.s[6]; bus.S8_i = r.s[7];
  endtask

  // One clock: apply inputs, then compare every output against the model 1 time unit after the edge
  task automatic step(input rec_t r);
    int n, src;
    logic flush, ev, ed, ep, emag;
    logic [7:0] c;
    logic [3:0] l;
    drive(r);
    hist.push_back(r);
    @(posedge clk);
    #1;
    n = hist.size() - 1;
    ev = 1'b0; ed = 1'b0; ep = 1'b0; emag = 1'b0; src = 0;
    if (n >= 3) begin
      src = n - 3;
      flush = 1'b0;
      for (int i = src; i <= n; i++) if (hist[i].rst) flush = 1'b1;
      if (!flush) begin
        ev = hist[src].valid; ed = hist[src].done; ep = hist[src].prog;
      end
    end
    if (hist[n].rst) begin
      m_code = '0; m_riu2 = '0; m_cnt = '0;
    end else begin
      if (ev) begin
        ref_out(hist[src], c, l, emag);
        m_code = c; m_riu2 = l;
      end
      m_cnt = m_prev_done ? TB_CNT_W'(ev) : m_cnt + TB_CNT_W'(ev);
    end
    m_prev_done = ed;
    exp_q.push_back(m_cnt);
    chk("valid_o", 32'(bus.valid_o), 32'(ev));
    chk("done_o", 32'(bus.done_o), 32'(ed));
    chk("progress_done_o", 32'(bus.progress_done_o), 32'(ep));
    chk("code_o", 32'(bus.code_o), 32'(m_code));
    chk("riu2_o", 32'(bus.riu2_o), 32'(m_riu2));
    chk("code_count_o", 32'(bus.code_count_o), 32'(exp_q.pop_front()));
`ifdef LBP_MAGNITUDE_EN
    if (hist[n].rst) chk("mag_o_rst", 32'(bus.mag_o), 32'd0);
    else if (ev)     chk("mag_o", 32'(bus.mag_o), 32'(emag));
`endif
  endtask

  task automatic idle(input int cycles);
    rec_t r;
    r.rst = 1'b0; r.valid = 1'b0; r.done = 1'b0; r.prog = 1'b0; r.center = '0;
    for (int k = 0; k < 8; k++) r.s[k] = '0;
    for (int i = 0; i < cycles; i++) step(r);
  endtask

  task automatic do_reset(input int cycles);
    rec_t r;
    r.rst = 1'b1; r.valid = 1'b0; r.done = 1'b0; r.prog = 1'b0; r.center = '0;
    for (int k = 0; k < 8; k++) r.s[k] = '0;
    for (int i = 0; i < cycles; i++) step(r);
  endtask

  task automatic rand_rec(output rec_t r);
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    r.rst = 1'b0; r.center = c;
    r.valid = ($urandom_range(0, 3) != 0);
    r.done  = ($urandom_range(0, 19) == 0);
    r.prog  = ($urandom_range(0, 7) == 0);
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: r.s[k] = 24'($urandom);
        1: r.s[k] = {c, 16'h0000};
        2: r.s[k] = {c, 16'h0000} - 24'd1;
        default: r.s[k] = {c, 16'h0000} + 24'($urandom_range(0, 65535));
      endcase
    end
  endtask

  vec_t tbl [6];
  rec_t r;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].center = 8'h80; tbl[0].s = '{8{24'h800000}};
    tbl[0].exp_code = 8'hFF; tbl[0].exp_riu2 = 4'd8;
    tbl[1].center = 8'h80;
    tbl[1].s = '{24'h900000, 24'h900000, 24'h900000, 24'h100000,
                 24'h100000, 24'h100000, 24'h100000, 24'h100000};
    tbl[1].exp_code = 8'h07; tbl[1].exp_riu2 = 4'd3;
    tbl[2].center = 8'h80;
    tbl[2].s = '{24'h900000, 24'h100000, 24'h900000, 24'h100000,
                 24'h900000, 24'h100000, 24'h900000, 24'h100000};
    tbl[2].exp_code = 8'h55; tbl[2].exp_riu2 = 4'd9;
    tbl[3].center = 8'h80;
    tbl[3].s = '{24'h7FFFFF, 24'h800000, 24'h800000, 24'h800000,
                 24'h800000, 24'h800000, 24'h800000, 24'h800000};
    tbl[3].exp_code = 8'hFE; tbl[3].exp_riu2 = 4'd7;
    tbl[4].center = 8'h7F;
    tbl[4].s = '{24'h7F8000, 24'h7EFFFF, 24'h7EFFFF, 24'h7EFFFF,
                 24'h7EFFFF, 24'h7EFFFF, 24'h7EFFFF, 24'h7EFFFF};
    tbl[4].exp_code = 8'h01; tbl[4].exp_riu2 = 4'd1;
    tbl[5].center = 8'hFF; tbl[5].s = '{8{24'h000000}};
    tbl[5].exp_code = 8'h00; tbl[5].exp_riu2 = 4'd0;

    do_reset(3);
    chk("reset_valid_o", 32'(bus.valid_o), 32'd0);
    chk("reset_code_count_o", 32'(bus.code_count_o), 32'd0);

    // Directed vector table: one beat, then read the result 4 cycles later
    for (int i = 0; i < 6; i++) begin
      r.rst = 1'b0; r.valid = 1'b1; r.done = 1'b0; r.prog = 1'b0;
      r.center = tbl[i].center; r.s = tbl[i].s;
      step(r);
      idle(3);
      chk("tbl_valid", 32'(bus.valid_o), 32'd1);
      chk("tbl_code", 32'(bus.code_o), 32'(tbl[i].exp_code));
      chk("tbl_riu2", 32'(bus.riu2_o), 32'(tbl[i].exp_riu2));
    end

    // Frame of 6 beats: progress on the 3rd, done on the 6th
    do_reset(1);
    for (int i = 1; i <= 6; i++) begin
      rand_rec(r);
      r.valid = 1'b1; r.done = (i == 6); r.prog = (i == 3);
      step(r);
    end
    chk("frame_prog_o", 32'(bus.progress_done_o), 32'd1);
    chk("frame_prog_valid", 32'(bus.valid_o), 32'd1);
    idle(3);
    chk("frame_done_o", 32'(bus.done_o), 32'd1);
    chk("frame_count6", 32'(bus.code_count_o), 32'd6);
    idle(1);
    chk("frame_count_clear", 32'(bus.code_count_o), 32'd0);
    chk("frame_done_drop", 32'(bus.done_o), 32'd0);

    // done/progress with no valid still travel through, 4 cycles late
    r.valid = 1'b0; r.done = 1'b1; r.prog = 1'b1; r.rst = 1'b0;
    step(r);
    idle(3);
    chk("bare_done_o", 32'(bus.done_o), 32'd1);
    chk("bare_prog_o", 32'(bus.progress_done_o), 32'd1);
    chk("bare_valid_o", 32'(bus.valid_o), 32'd0);

    // Reset right behind 3 valid beats: none of them may come out
    idle(2);
    for (int i = 0; i < 3; i++) begin
      rand_rec(r);
      r.valid = 1'b1; r.done = 1'b0; r.prog = 1'b0;
      step(r);
    end
    do_reset(2);
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_code_o", 32'(bus.code_o), 32'd0);
    chk("rst_riu2_o", 32'(bus.riu2_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("rst_flush_valid", 32'(bus.valid_o), 32'd0);
    end

    // Counter wraps modulo 2^CNT_W: 18 beats in a 4-bit counter reads 2
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      rand_rec(r);
      r.valid = 1'b1; r.done = 1'b0; r.prog = 1'b0;
      step(r);
    end
    idle(3);
    chk("wrap_count", 32'(bus.code_count_o), 32'd2);

`ifdef LBP_MAGNITUDE_EN
    r.rst = 1'b0; r.valid = 1'b1; r.done = 1'b0; r.prog = 1'b0; r.center = 8'd100;
    r.s = '{8{{8'd120, 16'h0000}}};
    step(r);
    r.s = '{8{{8'd110, 16'h0000}}};
    step(r);
    idle(2);
    chk("mag_120", 32'(bus.mag_o), 32'd1);
    idle(1);
    chk("mag_110", 32'(bus.mag_o), 32'd0);
`endif

    // Random traffic with occasional reset against the reference model
    for (int i = 0; i < 400; i++) begin
      rand_rec(r);
      r.rst = ($urandom_range(0, 99) == 0);
      step(r);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
